// File: rtl/cursor_controller_pkg.sv
// Shared cursor/renderer package: colour encoding and direction vector width.
package cursor_controller_pkg;

  localparam int COLOR_WIDTH = 3;
  localparam logic [COLOR_WIDTH-1:0] COLOR_NONE  = 3'd0;
  localparam logic [COLOR_WIDTH-1:0] COLOR_FIRST = 3'd1;
  localparam logic [COLOR_WIDTH-1:0] COLOR_LAST  = 3'd7;

  // One signed axis step: -1, 0 or +1.
  localparam int DIR_WIDTH = 2;

  // Next drawing colour; COLOR_NONE is skipped by wrapping LAST back to FIRST.
  function automatic logic [COLOR_WIDTH-1:0] next_color(input logic [COLOR_WIDTH-1:0] c);
    return (c == COLOR_LAST) ? COLOR_FIRST : c + COLOR_WIDTH'(1);
  endfunction

endpackage

// File: rtl/cursor_controller_key_repeat.sv
// key_repeat: press/hold-delay/auto-repeat FSM for the cursor direction vector.
// The step strobe is decided from the current key vector so the top can
// register the new coordinates on the very edge that sampled the key.
module key_repeat
  import cursor_controller_pkg::*;
#(
  parameter int REPEAT_DELAY  = 12_500_000,
  parameter int REPEAT_PERIOD = 2_500_000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic signed [DIR_WIDTH-1:0] dx,
  input  logic signed [DIR_WIDTH-1:0] dy,
  output logic                        step,
  output logic signed [DIR_WIDTH-1:0] step_dx,
  output logic signed [DIR_WIDTH-1:0] step_dy
);

  localparam int MAX_COUNT = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW        = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;

  typedef enum logic [1:0] {IDLE, HOLD_DELAY, REPEAT} state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            count_q, count_d;
  logic [2*DIR_WIDTH-1:0]   vec_q, vec_d;
  logic                     dir_active;
  logic                     vec_changed;

  assign dir_active  = (dx != '0) || (dy != '0);
  assign vec_changed = ({dx, dy} != vec_q);
  assign step_dx     = dx;
  assign step_dy     = dy;

  // Next-state logic: decide whether this edge moves the cursor.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    vec_d   = vec_q;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (dir_active) begin
          step    = 1'b1;
          count_d = '0;
          vec_d   = {dx, dy};
          state_d = HOLD_DELAY;
        end
      end
      HOLD_DELAY: begin
        if (!dir_active) begin
          state_d = IDLE;
          count_d = '0;
        end else if (vec_changed) begin
          step    = 1'b1;
          count_d = '0;
          vec_d   = {dx, dy};
        end else if (count_q == CW'(REPEAT_DELAY - 1)) begin
          step    = 1'b1;
          count_d = '0;
          state_d = REPEAT;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      REPEAT: begin
        if (!dir_active) begin
          state_d = IDLE;
          count_d = '0;
        end else if (vec_changed) begin
          step    = 1'b1;
          count_d = '0;
          vec_d   = {dx, dy};
          state_d = HOLD_DELAY;
        end else if (count_q == CW'(REPEAT_PERIOD - 1)) begin
          step    = 1'b1;
          count_d = '0;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  // FSM state, repeat counter and last direction vector.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      vec_q   <= vec_d;
    end
  end

endmodule

// File: rtl/cursor_controller.sv
// cursor_controller: keys -> cursor position, move pulse and drawing colour.
// Build option CURSOR_WRAP_EN: coordinates wrap at the screen edges instead
// of saturating.
module cursor_controller
  import cursor_controller_pkg::*;
#(
  parameter int WIDTH         = 640,
  parameter int HEIGHT        = 480,
  parameter int REPEAT_DELAY  = 12_500_000,
  parameter int REPEAT_PERIOD = 2_500_000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       key_up,
  input  logic                       key_down,
  input  logic                       key_left,
  input  logic                       key_right,
  input  logic                       key_color,
  output logic [$clog2(WIDTH)-1:0]   cursor_x,
  output logic [$clog2(HEIGHT)-1:0]  cursor_y,
  output logic [COLOR_WIDTH-1:0]     current_color,
  output logic                       moved
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);

  logic signed [DIR_WIDTH-1:0] dx, dy, step_dx, step_dy;
  logic                        step;
  logic [XW-1:0]               x_q, x_d;
  logic [YW-1:0]               y_q, y_d;
  logic                        moved_q, moved_d;
  logic [COLOR_WIDTH-1:0]      color_q, color_d;
  logic                        key_color_q;
  int                          nx, ny;

  // Opposing keys cancel; each axis is -1, 0 or +1.
  assign dx = $signed({1'b0, key_right}) - $signed({1'b0, key_left});
  assign dy = $signed({1'b0, key_down})  - $signed({1'b0, key_up});

  key_repeat #(
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) u_key_repeat (
    .clk     (clk),
    .reset   (reset),
    .dx      (dx),
    .dy      (dy),
    .step    (step),
    .step_dx (step_dx),
    .step_dy (step_dy)
  );

  // Apply a step to both axes, then clamp or wrap each axis independently.
  always_comb begin
    nx = int'(x_q) + int'(step_dx);
    ny = int'(y_q) + int'(step_dy);
`ifdef CURSOR_WRAP_EN
    if (nx < 0)            nx = WIDTH - 1;
    else if (nx > WIDTH-1) nx = 0;
    if (ny < 0)             ny = HEIGHT - 1;
    else if (ny > HEIGHT-1) ny = 0;
`else
    if (nx < 0)            nx = 0;
    else if (nx > WIDTH-1) nx = WIDTH - 1;
    if (ny < 0)             ny = 0;
    else if (ny > HEIGHT-1) ny = HEIGHT - 1;
`endif
    x_d     = step ? XW'(nx) : x_q;
    y_d     = step ? YW'(ny) : y_q;
    moved_d = step && ((x_d != x_q) || (y_d != y_q));
  end

  // Colour advances once per rising edge of key_color.
  always_comb begin
    color_d = color_q;
    if (key_color && !key_color_q) color_d = next_color(color_q);
  end

  // Registered outputs and key_color history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q         <= XW'(WIDTH / 2);
      y_q         <= YW'(HEIGHT / 2);
      moved_q     <= 1'b0;
      color_q     <= COLOR_FIRST;
      key_color_q <= 1'b0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      moved_q     <= moved_d;
      color_q     <= color_d;
      key_color_q <= key_color;
    end
  end

  assign cursor_x      = x_q;
  assign cursor_y      = y_q;
  assign moved         = moved_q;
  assign current_color = color_q;

endmodule

// File: tb/tb_cursor_controller.sv
// Directed bench for cursor_controller on an 8x8 screen, delay 4, period 2.
// Expected values are hand-computed; CURSOR_WRAP_EN selects wrap expectations.
module tb_cursor_controller;
  import cursor_controller_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_up, key_down, key_left, key_right, key_color;
  logic [2:0] cursor_x, cursor_y;
  logic [COLOR_WIDTH-1:0] current_color;
  logic       moved;

  int checks   = 0;
  int failures = 0;

  cursor_controller #(
    .WIDTH(8), .HEIGHT(8), .REPEAT_DELAY(4), .REPEAT_PERIOD(2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .key_up        (key_up),
    .key_down      (key_down),
    .key_left      (key_left),
    .key_right     (key_right),
    .key_color     (key_color),
    .cursor_x      (cursor_x),
    .cursor_y      (cursor_y),
    .current_color (current_color),
    .moved         (moved)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s got=%0d", tag, got);
    end
  endtask

  // Advance n clock edges, then settle 1 time unit past the last edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_pos(input string tag, input int ex, input int ey, input int em);
    check({tag, ".x"}, int'(cursor_x), ex);
    check({tag, ".y"}, int'(cursor_y), ey);
    check({tag, ".moved"}, int'(moved), em);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    {key_up, key_down, key_left, key_right, key_color} = '0;

    // 1. reset state
    tick(2);
    check_pos("rst_held", 4, 4, 0);
    check("rst_held.color", int'(current_color), int'(COLOR_FIRST));
    reset = 1'b1;
    tick(1);
    check_pos("rst_rel", 4, 4, 0);

    // 2. one-cycle tap, then hold right into the clamp
    key_right = 1'b1; tick(1);
    check_pos("tap_r", 5, 4, 1);
    key_right = 1'b0; tick(1);
    check_pos("tap_r_rel", 5, 4, 0);
    key_right = 1'b1; tick(1);
    check_pos("hold_r_e0", 6, 4, 1);
    tick(3);
    check_pos("hold_r_e3", 6, 4, 0);
    tick(1);
    check_pos("hold_r_e4", 7, 4, 1);
    tick(2);
    check_pos("hold_r_e6", 7, 4, 0);
    tick(2);
    check_pos("hold_r_e8", 7, 4, 0);
    key_right = 1'b0; tick(1);

    // 3. walk to x=0 with taps, then hold left against the edge
    do_reset();
    for (int i = 0; i < 4; i++) begin
      key_left = 1'b1; tick(1);
      key_left = 1'b0; tick(1);
    end
    check_pos("tap_l_x0", 0, 4, 0);
    key_left = 1'b1; tick(1);
`ifdef CURSOR_WRAP_EN
    check_pos("edge_l_e0", 7, 4, 1);
    tick(4);
    check_pos("edge_l_e4", 6, 4, 1);
`else
    check_pos("edge_l_e0", 0, 4, 0);
    tick(4);
    check_pos("edge_l_e4", 0, 4, 0);
`endif
    key_left = 1'b0; tick(1);

    // 4. cancelling keys, then a diagonal step
    do_reset();
    key_up = 1'b1; key_down = 1'b1; tick(3);
    check_pos("up_down", 4, 4, 0);
    key_up = 1'b0; key_down = 1'b0; tick(1);
    key_up = 1'b1; key_right = 1'b1; tick(1);
    check_pos("diag_ur", 5, 3, 1);
    key_up = 1'b0; key_right = 1'b0; tick(1);

    // 5. colour wraps after LAST-FIRST+1 presses; a held key advances once
    for (int i = 1; i <= int'(COLOR_LAST - COLOR_FIRST) + 1; i++) begin
      key_color = 1'b1; tick(1);
      check($sformatf("color_p%0d", i), int'(current_color),
            (i == int'(COLOR_LAST - COLOR_FIRST) + 1) ? int'(COLOR_FIRST) : int'(COLOR_FIRST) + i);
      key_color = 1'b0; tick(1);
    end
    key_color = 1'b1; tick(1);
    check("color_hold_1", int'(current_color), int'(COLOR_FIRST) + 1);
    tick(9);
    check("color_hold_10", int'(current_color), int'(COLOR_FIRST) + 1);
    key_color = 1'b0; tick(1);

    // 6. asynchronous reset during repeat with the key still held
    key_right = 1'b1; tick(1);
    check_pos("rr_e0", 6, 3, 1);
    tick(4);
    check_pos("rr_e4", 7, 3, 1);
    reset = 1'b0; #1;
    check_pos("rr_async", 4, 4, 0);
    check("rr_async.color", int'(current_color), int'(COLOR_FIRST));
    reset = 1'b1;
    tick(1);
    check_pos("rr_rel_e0", 5, 4, 1);
    tick(3);
    check_pos("rr_rel_e3", 5, 4, 0);
    tick(1);
    check_pos("rr_rel_e4", 6, 4, 1);
    key_right = 1'b0; tick(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
